// File: rtl/wide_add_sequencer_if.sv
// Handshake/bus bundle for wide_add_sequencer.
// Optional feature macro: ADD_OVF_EN (adds the signed-overflow flag ovf).
// master = operand producer / result consumer side, slave = the sequencer.
interface wide_add_sequencer_if #(
    parameter int WIDTH = 16
);
    // Operand side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;

    // Result side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADD_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: WIDTH-bit add done as WIDTH/4 passes of one shared
// 4-bit ripple slice, least-significant nibble first, carry fed back
// through carry_q. valid/ready handshake on operand and result sides.
// Optional feature macro: ADD_OVF_EN (two's-complement overflow flag ovf).
module wide_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    wide_add_sequencer_if.slave  bus
);

    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [N-1:0][3:0]   a_q, a_d;
    logic [N-1:0][3:0]   b_q, b_d;
    logic [N-1:0][3:0]   sum_q, sum_d;
    logic                carry_q, carry_d;
    logic                cout_q, cout_d;
    logic                in_ready_q, in_ready_d;
`ifdef ADD_OVF_EN
    logic                ovf_q, ovf_d;
    logic                carry_into_msb;
`endif

    // The single shared 4-bit adder slice, steered by k_q.
    logic [3:0] slice_a;
    logic [3:0] slice_b;
    logic [3:0] slice_sum;
    logic       slice_co;

    assign slice_a = a_q[k_q];
    assign slice_b = b_q[k_q];
    assign {slice_co, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, carry_q};

`ifdef ADD_OVF_EN
    // Carry into the top bit recovered from the sum bit and its operands.
    assign carry_into_msb = slice_sum[3] ^ slice_a[3] ^ slice_b[3];
`endif

    // Next-state and datapath update for the IDLE / RUN / DONE sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    k_d     = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
`ifdef ADD_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[k_q] = slice_sum;
                carry_d    = slice_co;
                k_d        = k_q + K_ONE;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    cout_d  = slice_co;
`ifdef ADD_OVF_EN
                    ovf_d   = carry_into_msb ^ slice_co;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // in_ready is registered so it is low through the reset edge and
        // rises on the edge that returns the sequencer to IDLE.
        in_ready_d = (state_d == IDLE);
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (rst) begin
            // NOTE: operand registers are reset along with the visible
            // outputs; they are few and this keeps the slice inputs defined.
            state_q    <= IDLE;
            k_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            cout_q     <= 1'b0;
            in_ready_q <= 1'b0;
`ifdef ADD_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            cout_q     <= cout_d;
            in_ready_q <= in_ready_d;
`ifdef ADD_OVF_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef ADD_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (WIDTH=16): directed vectors
// with hand-computed sums, backpressure, mid-run reset, then 1000 random
// operations against a plain a+b+cin reference.
// Optional feature macro: ADD_OVF_EN (ovf checks are compiled in with it).
module tb_wide_add_sequencer;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wide_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

    wide_add_sequencer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; all driving and sampling happens 1 ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid, counting edges after the accept; in_ready must stay low.
    task automatic wait_done(output int lat, output int ready_seen);
        lat        = 0;
        ready_seen = 0;
        while (!bus.out_valid && lat < 20) begin
            if (bus.in_ready) ready_seen = 1;
            tick;
            lat++;
        end
    endtask

    // One complete directed operation with hand-computed expected results.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic [15:0] exp_sum, input logic exp_cout);
        int lat;
        int ready_seen;
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = ci;
        bus.in_valid = 1'b1;
        tick;  // accept edge E0
        bus.in_valid = 1'b0;
        bus.a        = ~a;  // must be ignored after accept
        bus.b        = ~b;
        bus.cin      = ~ci;
        wait_done(lat, ready_seen);
        // out_valid becomes visible in the cycle following edge E_N
        check("latency", 32'(lat), 32'(N));
        check("in_ready_run", 32'(ready_seen), 32'd0);
        check("in_ready_done", 32'(bus.in_ready), 32'd0);
        check("sum", 32'(bus.sum), 32'(exp_sum));
        check("cout", 32'(bus.cout), 32'(exp_cout));
`ifdef ADD_OVF_EN
        check("ovf", 32'(bus.ovf), 32'((a[15] == b[15]) && (exp_sum[15] != a[15])));
`endif
        bus.out_ready = 1'b1;
        tick;  // handshake edge
        bus.out_ready = 1'b0;
        check("out_valid_drop", 32'(bus.out_valid), 32'd0);
        check("in_ready_rise", 32'(bus.in_ready), 32'd1);
        check("sum_hold", 32'(bus.sum), 32'(exp_sum));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ready_seen;
        int n_results;
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] rexp;
        logic        done;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        rst           = 1'b1;

        // Reset state
        tick;
        tick;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
`ifdef ADD_OVF_EN
        check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        rst = 1'b0;
        tick;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed vectors
        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op(16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1);
        run_op(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);

        // Backpressure: result held for 10 cycles, in_valid held through DONE
        bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        wait_done(lat, ready_seen);
        check("bp_latency", 32'(lat), 32'(N));
        bus.a = 16'h0001; bus.b = 16'h0002; bus.cin = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("bp_stable", {13'd0, bus.in_ready, bus.out_valid, bus.cout, bus.sum},
                  {13'd0, 1'b0, 1'b1, 1'b0, 16'h3333});
        end
        bus.out_ready = 1'b1;
        tick;  // handshake edge
        bus.out_ready = 1'b0;
        check("bp_idle_after_hs", 32'(bus.in_ready), 32'd1);
        check("bp_valid_after_hs", 32'(bus.out_valid), 32'd0);
        tick;  // held in_valid accepted here
        bus.in_valid = 1'b0;
        check("bp_accepted", 32'(bus.in_ready), 32'd0);
        wait_done(lat, ready_seen);
        check("bp2_latency", 32'(lat), 32'(N));
        check("bp2_sum", 32'(bus.sum), 32'h0004);
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;

        // Reset in the second RUN cycle
        bus.a = 16'h1111; bus.b = 16'h1111; bus.cin = 1'b0; bus.in_valid = 1'b1;
        tick;  // E0
        bus.in_valid = 1'b0;
        tick;  // E1: nibble 0 committed
        check("mid_partial", 32'(bus.sum), 32'h0002);
        rst = 1'b1;
        tick;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_sum", 32'(bus.sum), 32'd0);
        check("mid_rst_cout", 32'(bus.cout), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        tick;
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);

        // Random operations with random out_ready (also toggled while busy)
        n_results = 0;
        for (int op = 0; op < 1000; op++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom_range(0, 1));
            rexp = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            repeat ($urandom_range(0, 2)) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                tick;
            end
            bus.a = ra; bus.b = rb; bus.cin = rc; bus.in_valid = 1'b1;
            lat = 0;
            while (!bus.in_ready && lat < 10) begin
                tick;
                lat++;
            end
            if (!bus.in_ready) check("rand_ready_timeout", 32'd0, 32'd1);
            tick;  // accept
            bus.in_valid = 1'b0;
            done = 1'b0;
            for (int c = 0; c < 60 && !done; c++) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                if (bus.out_valid && bus.out_ready) begin
                    check("rand_sum", 32'(bus.sum), 32'(rexp[15:0]));
                    check("rand_cout", 32'(bus.cout), 32'(rexp[16]));
                    n_results++;
                    done = 1'b1;
                end
                tick;
            end
            bus.out_ready = 1'b0;
            if (!done) check("rand_done_timeout", 32'd0, 32'd1);
            check("rand_no_dup", 32'(bus.out_valid), 32'd0);
        end
        check("rand_result_count", 32'(n_results), 32'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
